// File: rtl/cl_serial_unit_pkg.sv
// Shared definitions for the bit-serial logic unit: op codes and FSM states.
// The optional serial parity output is enabled with CL_SERIAL_PARITY_EN.
package cl_serial_unit_pkg;

    // Op codes, which double as the select lines of the cl cell.
    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOT = 2'b11;

    // Control FSM states.
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/cl_serial_unit_cl.sv
// One-bit logic cell cl and its 4:1 mux. The cell computes AND, OR, XOR or
// NOT A on one bit pair, selected by s with the package op-code encoding.
module mux4_1 (
    input  logic       d0,
    input  logic       d1,
    input  logic       d2,
    input  logic       d3,
    input  logic [1:0] sel,
    output logic       y
);
    // Plain 4-way select.
    always_comb begin
        y = d0;
        case (sel)
            2'b00:   y = d0;
            2'b01:   y = d1;
            2'b10:   y = d2;
            default: y = d3;
        endcase
    end
endmodule

module cl
    import cl_serial_unit_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic [1:0] s,
    output logic       out
);
    logic d_and;
    logic d_or;
    logic d_xor;
    logic d_not;

    assign d_and = a & b;
    assign d_or  = a | b;
    assign d_xor = a ^ b;
    assign d_not = ~a;

    // Mux inputs are ordered to match OP_AND, OP_OR, OP_XOR and OP_NOT.
    mux4_1 u_mux (
        .d0  (d_and),
        .d1  (d_or),
        .d2  (d_xor),
        .d3  (d_not),
        .sel (s),
        .y   (out)
    );
endmodule

// File: rtl/cl_serial_unit.sv
// Bit-serial N-bit logic unit. It captures the operands on an accepted start
// and feeds them LSB first through the cl cell, one bit per clock. It then
// presents the reassembled word on result with a one-cycle done pulse.
// Handshake: start is sampled only in IDLE. done is a single-cycle pulse, and
// result is valid from that cycle until the next done.
// Defining CL_SERIAL_PARITY_EN adds a serially accumulated parity output.
module cl_serial_unit
    import cl_serial_unit_pkg::*;
#(
    parameter  int N  = 8,
    localparam int CW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] b_in,
    input  logic [1:0]   op,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
`ifdef CL_SERIAL_PARITY_EN
    ,
    output logic         parity
`endif
);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    state_e        state_q,  state_d;
    logic [N-1:0]  a_sh_q,   a_sh_d;
    logic [N-1:0]  b_sh_q,   b_sh_d;
    logic [N-1:0]  r_sh_q,   r_sh_d;
    logic [N-1:0]  result_q, result_d;
    logic [1:0]    op_r_q,   op_r_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic          cl_out;
    logic [N-1:0]  r_next;
`ifdef CL_SERIAL_PARITY_EN
    logic          par_acc_q, par_acc_d;
    logic          parity_q,  parity_d;
`endif

    // Per-bit operation on the current LSBs.
    cl u_cl (
        .a   (a_sh_q[0]),
        .b   (b_sh_q[0]),
        .s   (op_r_q),
        .out (cl_out)
    );

    // The result word as it stands after this cycle's bit is shifted in.
    assign r_next = {cl_out, r_sh_q[N-1:1]};

    // Next-state and datapath updates; every register holds by default.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        r_sh_d   = r_sh_q;
        result_d = result_q;
        op_r_d   = op_r_q;
        cnt_d    = cnt_q;
`ifdef CL_SERIAL_PARITY_EN
        par_acc_d = par_acc_q;
        parity_d  = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sh_d  = a_in;
                    b_sh_d  = b_in;
                    op_r_d  = op;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
`ifdef CL_SERIAL_PARITY_EN
                    par_acc_d = 1'b0;
`endif
                end
            end
            S_SHIFT: begin
                r_sh_d = r_next;
                a_sh_d = {1'b0, a_sh_q[N-1:1]};
                b_sh_d = {1'b0, b_sh_q[N-1:1]};
                cnt_d  = cnt_q + 1'b1;
`ifdef CL_SERIAL_PARITY_EN
                par_acc_d = par_acc_q ^ cl_out;
`endif
                if (cnt_q == CNT_LAST) begin
                    result_d = r_next;
                    state_d  = S_DONE;
`ifdef CL_SERIAL_PARITY_EN
                    parity_d = par_acc_q ^ cl_out;
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            r_sh_q   <= '0;
            result_q <= '0;
            op_r_q   <= '0;
            cnt_q    <= '0;
`ifdef CL_SERIAL_PARITY_EN
            par_acc_q <= 1'b0;
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            r_sh_q   <= r_sh_d;
            result_q <= result_d;
            op_r_q   <= op_r_d;
            cnt_q    <= cnt_d;
`ifdef CL_SERIAL_PARITY_EN
            par_acc_q <= par_acc_d;
            parity_q  <= parity_d;
`endif
        end
    end

    assign busy   = (state_q == S_SHIFT);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
`ifdef CL_SERIAL_PARITY_EN
    assign parity = parity_q;
`endif

endmodule

// File: tb/tb_cl_serial_unit.sv
// Directed bench for cl_serial_unit with N=8 and hand-computed results.
// The parity output is checked when CL_SERIAL_PARITY_EN is defined.
module tb_cl_serial_unit;
    localparam int N = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] a_in;
    logic [N-1:0] b_in;
    logic [1:0]   op;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
`ifdef CL_SERIAL_PARITY_EN
    logic         parity;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [N-1:0] prev_res;
    int done_cnt;

    cl_serial_unit #(.N(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a_in   (a_in),
        .b_in   (b_in),
        .op     (op),
        .busy   (busy),
        .done   (done),
        .result (result)
`ifdef CL_SERIAL_PARITY_EN
        ,
        .parity (parity)
`endif
    );

    // Clock: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison point.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation from IDLE. Busy, done and the held result are
    // checked through SHIFT; done, result and parity are checked in DONE.
    // The task returns one cycle after done, in IDLE.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [1:0] o, input logic [N-1:0] exp, input string tag);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        op    = o;
        tick();
        start = 1'b0;
        a_in  = ~a;
        b_in  = ~b;
        op    = ~o;
        for (int i = 0; i < N; i++) begin
            check({tag, "_busy"}, busy, 1'b1);
            check({tag, "_nodone"}, done, 1'b0);
            check({tag, "_hold"}, result, prev_res);
            if (i != N - 1) tick();
        end
        tick();
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_busy_lo"}, busy, 1'b0);
        check({tag, "_result"}, result, exp);
`ifdef CL_SERIAL_PARITY_EN
        check({tag, "_parity"}, parity, ^exp);
`endif
        tick();
        check({tag, "_pulse_end"}, done, 1'b0);
        check({tag, "_result_held"}, result, exp);
        prev_res = exp;
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        a_in     = '0;
        b_in     = '0;
        op       = 2'b00;
        prev_res = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_result", result, 8'h00);
`ifdef CL_SERIAL_PARITY_EN
        check("rst_parity", parity, 1'b0);
`endif
        rst_n = 1'b1;
        tick();

        // AND, XOR and OR on the same operands, then NOT A with B ignored.
        // Each op is issued in the cycle after the previous done.
        run_op(8'hC3, 8'hA5, 2'b00, 8'h81, "and");
        run_op(8'hC3, 8'hA5, 2'b10, 8'h66, "xor");
        run_op(8'hC3, 8'hA5, 2'b01, 8'hE7, "or");
        run_op(8'h0F, 8'hFF, 2'b11, 8'hF0, "not");
        run_op(8'h12, 8'h34, 2'b10, 8'h26, "xor_odd");

        // Start held high, with a_in and op changed during SHIFT. Accepts
        // land on edges 1 and 11, so done is high only at samples 9 and 19.
        start = 1'b1;
        a_in  = 8'hC3;
        b_in  = 8'hA5;
        op    = 2'b10;
        done_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 3) begin
                a_in = 8'hFF;
                op   = 2'b00;
            end
            if (done) done_cnt++;
            if (k == 9) begin
                check("held_done1", done, 1'b1);
                check("held_res1", result, 8'h66);
            end
            if (k == 10) check("held_idle_gap", busy, 1'b0);
            if (k == 11) check("held_reaccept", busy, 1'b1);
            if (k == 19) begin
                check("held_done2", done, 1'b1);
                check("held_res2", result, 8'hA5);
            end
        end
        start = 1'b0;
        check("held_done_count", done_cnt, 2);
        prev_res = 8'hA5;
        tick();

        // Asynchronous reset during the fourth SHIFT cycle aborts the op.
        start = 1'b1;
        a_in  = 8'hC3;
        b_in  = 8'hA5;
        op    = 2'b00;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("abort_busy_pre", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_result", result, 8'h00);
`ifdef CL_SERIAL_PARITY_EN
        check("abort_parity", parity, 1'b0);
`endif
        tick();
        rst_n = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done || busy) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);
        prev_res = 8'h00;

        // A normal operation after the aborted one.
        run_op(8'hC3, 8'hA5, 2'b00, 8'h81, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
